// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Accumulates the four per-filter partial sums coming out of computing_core
//   across cfg_nch input-channel passes, one buffer entry per output pixel, then
//   drains the requantized results (arithmetic shift + saturate) over a
//   valid/ready stream.
//
//   Optional feature: define PSUM_RELU_EN to clamp negative results to 0 after
//   saturation (fused ReLU). Undefined: signed saturated results pass unchanged.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   cfg_start                  1-cycle pulse, captures cfg_* and starts a run (IDLE only)
//   cfg_npix [AW:0]            output pixels per pass (0 treated as 1)
//   cfg_nch  [7:0]             passes per run (0 treated as 1)
//   cfg_shift[4:0]             arithmetic right shift before saturation
//   in_psum0..3, in_psum_vld   partial sums, all lanes valid together, no backpressure
//   out_data0..3, out_vld      requantized results
//   out_ready                  consumer handshake
//   busy                       ACCUM or DRAIN
//   done                       1-cycle pulse after the last beat is accepted
//   err_ovr                    sticky: psum valid seen outside ACCUM

// One lane: accumulation buffer plus the combinational requantizer on the
// drain read port.
module psum_lane #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 20,
   parameter int DEPTH     = 256,
   parameter int AW        = 8
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic             first,     // first pass: overwrite instead of add
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] psum,
   input  logic [AW-1:0]    rd_addr,
   input  logic [4:0]       shift,
   output logic [WIDTH-1:0] q
);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (WIDTH-1)) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   logic signed [ACC_WIDTH-1:0] mem [DEPTH];
   logic signed [WIDTH-1:0]     psum_s;
   logic signed [ACC_WIDTH-1:0] psum_ext, base, rd_val, shifted, sat;

   assign psum_s   = psum;
   assign psum_ext = ACC_WIDTH'(psum_s);           // sign extension
   // Pass 0 ignores whatever the buffer held, so no buffer reset is needed.
   assign base     = first ? '0 : mem[wr_addr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= base + psum_ext;  // wraps modulo 2^ACC_WIDTH
   end

   assign rd_val  = mem[rd_addr];
   assign shifted = rd_val >>> shift;

   always_comb begin
      if (shifted > SAT_MAX)      sat = SAT_MAX;
      else if (shifted < SAT_MIN) sat = SAT_MIN;
      else                        sat = shifted;
      q = sat[WIDTH-1:0];
`ifdef PSUM_RELU_EN
      if (sat < 0) q = '0;
`endif
   end
endmodule

module psum_accumulator #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 20,
   parameter int DEPTH     = 256,
   parameter int AW        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic [AW:0]      cfg_npix,
   input  logic [7:0]       cfg_nch,
   input  logic [4:0]       cfg_shift,
   input  logic [WIDTH-1:0] in_psum0,
   input  logic [WIDTH-1:0] in_psum1,
   input  logic [WIDTH-1:0] in_psum2,
   input  logic [WIDTH-1:0] in_psum3,
   input  logic             in_psum_vld,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [WIDTH-1:0] out_data3,
   output logic             out_vld,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic             err_ovr
);
   localparam int NUM_LANES = 4;

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;
   state_t state, state_nxt;

   logic [AW:0] npix_r, pix_cnt, rd_cnt;
   logic [7:0]  nch_r, ch_cnt;
   logic [4:0]  shift_r;
   logic        acc_beat, pix_last, ch_last, load, last_acc;

   logic [NUM_LANES-1:0][WIDTH-1:0] psum_in, lane_q, out_q;

   assign psum_in = {in_psum3, in_psum2, in_psum1, in_psum0};

   assign acc_beat = (state == S_ACCUM) && in_psum_vld;
   assign pix_last = pix_cnt == npix_r - 1'b1;
   assign ch_last  = ch_cnt == nch_r - 1'b1;
   // rd_cnt counts pixels already loaded into the output register; it reaches
   // npix_r while the final beat is still waiting to be accepted.
   assign load     = (state == S_DRAIN) && (rd_cnt != npix_r) && (!out_vld || out_ready);
   assign last_acc = (state == S_DRAIN) && (rd_cnt == npix_r) && out_vld && out_ready;

   genvar k;
   generate
      for (k = 0; k < NUM_LANES; k++) begin : g_lane
         psum_lane #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_lane (
            .clk     (clk),
            .wr_en   (acc_beat),
            .first   (ch_cnt == 8'd0),
            .wr_addr (pix_cnt[AW-1:0]),
            .psum    (psum_in[k]),
            .rd_addr (rd_cnt[AW-1:0]),
            .shift   (shift_r),
            .q       (lane_q[k])
         );
      end
   endgenerate

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (cfg_start) state_nxt = S_ACCUM;
         S_ACCUM: if (acc_beat && pix_last && ch_last) state_nxt = S_DRAIN;
         S_DRAIN: if (last_acc) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         npix_r  <= (AW+1)'(1);
         nch_r   <= 8'd1;
         shift_r <= '0;
         pix_cnt <= '0;
         ch_cnt  <= '0;
         rd_cnt  <= '0;
         out_q   <= '0;
         out_vld <= 1'b0;
         err_ovr <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state == S_IDLE && cfg_start) begin
            npix_r  <= (cfg_npix == '0) ? (AW+1)'(1) : cfg_npix;
            nch_r   <= (cfg_nch == '0) ? 8'd1 : cfg_nch;
            shift_r <= cfg_shift;
            pix_cnt <= '0;
            ch_cnt  <= '0;
            rd_cnt  <= '0;
            err_ovr <= 1'b0;
         end else if (in_psum_vld && state != S_ACCUM) begin
            err_ovr <= 1'b1;
         end

         if (acc_beat) begin
            if (pix_last) begin
               pix_cnt <= '0;
               ch_cnt  <= ch_cnt + 8'd1;
            end else begin
               pix_cnt <= pix_cnt + 1'b1;
            end
         end

         if (load) begin
            out_q   <= lane_q;
            out_vld <= 1'b1;
            rd_cnt  <= rd_cnt + 1'b1;
         end else if (last_acc) begin
            out_vld <= 1'b0;
         end
      end
   end

   assign out_data0 = out_q[0];
   assign out_data1 = out_q[1];
   assign out_data2 = out_q[2];
   assign out_data3 = out_q[3];
   assign busy      = (state == S_ACCUM) || (state == S_DRAIN);
   assign done      = (state == S_DONE);
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: hand-computed expected outputs per
// lane and pixel, drained through a valid/ready consumer with optional stalls.
module tb_psum_accumulator;
   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_start;
   logic [8:0] cfg_npix;
   logic [7:0] cfg_nch;
   logic [4:0] cfg_shift;
   logic [7:0] in_psum0, in_psum1, in_psum2, in_psum3;
   logic       in_psum_vld;
   logic [7:0] out_data0, out_data1, out_data2, out_data3;
   logic       out_vld, out_ready, busy, done, err_ovr;

   int checks = 0;
   int errors = 0;
   int exp_q [4][8];

   psum_accumulator dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_npix(cfg_npix),
      .cfg_nch(cfg_nch), .cfg_shift(cfg_shift),
      .in_psum0(in_psum0), .in_psum1(in_psum1), .in_psum2(in_psum2), .in_psum3(in_psum3),
      .in_psum_vld(in_psum_vld),
      .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
      .out_vld(out_vld), .out_ready(out_ready), .busy(busy), .done(done), .err_ovr(err_ovr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected-value post-processing for the optional fused ReLU.
   function automatic int rq(input int x);
`ifdef PSUM_RELU_EN
      return (x < 0) ? 0 : x;
`else
      return x;
`endif
   endfunction

   function automatic int od(input int k);
      case (k)
         0: return int'($signed(out_data0));
         1: return int'($signed(out_data1));
         2: return int'($signed(out_data2));
         default: return int'($signed(out_data3));
      endcase
   endfunction

   task automatic set_exp(input int p, input int a, input int b, input int c, input int d);
      exp_q[0][p] = rq(a); exp_q[1][p] = rq(b); exp_q[2][p] = rq(c); exp_q[3][p] = rq(d);
   endtask

   // All tasks start and end just after a falling edge.
   task automatic run_cfg(input int npix, input int nch, input int shift);
      cfg_npix = npix[8:0]; cfg_nch = nch[7:0]; cfg_shift = shift[4:0];
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   task automatic beat(input int a, input int b, input int c, input int d);
      in_psum0 = a[7:0]; in_psum1 = b[7:0]; in_psum2 = c[7:0]; in_psum3 = d[7:0];
      in_psum_vld = 1'b1;
      @(negedge clk);
      in_psum_vld = 1'b0;
   endtask

   // Drain n pixels; out_ready is low on cycles stall_lo..stall_hi of the drain.
   // lat_exp < 0 skips the first-valid latency check.
   task automatic collect(input int n, input int lat_exp, input int stall_lo, input int stall_hi);
      int idx = 0, cyc = 0, first = -1;
      while (idx < n && cyc < 60) begin
         out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
         if (out_vld) begin
            if (first < 0) first = cyc;
            for (int k = 0; k < 4; k++)
               chk(out_ready ? "beat_data" : "hold_data", od(k), exp_q[k][idx]);
            if (out_ready) idx++;
         end
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b1;
      chk("beat_count", idx, n);
      if (lat_exp >= 0) chk("first_vld_lat", first, lat_exp);
      chk("done_high", int'(done), 1);
      chk("vld_dropped", int'(out_vld), 0);
      chk("busy_low", int'(busy), 0);
      @(negedge clk);
      chk("done_pulse_end", int'(done), 0);
   endtask

   task automatic test1;
      run_cfg(4, 1, 0);
      beat(1, -1, 10, -128);
      beat(2, -2, 20, -128);
      beat(3, -3, 30, -128);
      beat(4, -4, 40, -128);
      for (int p = 0; p < 4; p++) set_exp(p, p + 1, -(p + 1), 10 * (p + 1), -128);
      collect(4, 1, -1, -2);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_out0"}, od(0), 0);
      chk({tag, "_out1"}, od(1), 0);
      chk({tag, "_out2"}, od(2), 0);
      chk({tag, "_out3"}, od(3), 0);
      chk({tag, "_vld"}, int'(out_vld), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_err"}, int'(err_ovr), 0);
   endtask

   initial begin
      rst = 1'b1; cfg_start = 1'b0; cfg_npix = '0; cfg_nch = '0; cfg_shift = '0;
      in_psum0 = '0; in_psum1 = '0; in_psum2 = '0; in_psum3 = '0;
      in_psum_vld = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      reset_checks("reset");

      // 1: simple single pass, output order and done pulse
      test1();

      // 2: three passes over two pixels; a cfg_start mid-run must be ignored
      run_cfg(2, 3, 0);
      for (int i = 0; i < 6; i++) begin
         if (i == 2) begin cfg_npix = 9'd1; cfg_nch = 8'd1; cfg_start = 1'b1; end
         beat(10, 10, 10, 10);
         cfg_start = 1'b0;
         chk("t2_no_vld", int'(out_vld), 0);
         chk("t2_busy", int'(busy), 1);
      end
      set_exp(0, 30, 30, 30, 30);
      set_exp(1, 30, 30, 30, 30);
      collect(2, 1, -1, -2);

      // 3: saturation of accumulated sums
      run_cfg(1, 2, 0);
      beat(5, 100, -100, 0);
      beat(6, 100, -100, 0);
      set_exp(0, 11, 127, -128, 0);
      collect(1, 1, -1, -2);

      // 4: arithmetic shift rounds toward minus infinity
      run_cfg(1, 1, 2);
      beat(7, 127, -1, -7);
      set_exp(0, 1, 31, -1, -2);
      collect(1, 1, -1, -2);

      // 5: stalled drain plus a stray psum during DRAIN
      run_cfg(3, 1, 0);
      beat(11, -11, 1, 2);
      beat(22, -22, 3, 4);
      beat(33, -33, 5, 6);
      in_psum0 = 8'd99; in_psum_vld = 1'b1;
      @(negedge clk);
      in_psum_vld = 1'b0;
      chk("t5_err_set", int'(err_ovr), 1);
      set_exp(0, 11, -11, 1, 2);
      set_exp(1, 22, -22, 3, 4);
      set_exp(2, 33, -33, 5, 6);
      collect(3, 0, 1, 3);
      chk("t5_err_sticky", int'(err_ovr), 1);

      // 6: reset mid-ACCUM, then a clean rerun of test 1
      run_cfg(4, 2, 0);
      chk("t6_err_cleared", int'(err_ovr), 0);
      beat(50, 50, 50, 50);
      beat(60, 60, 60, 60);
      beat(70, 70, 70, 70);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      reset_checks("midrst");
      test1();

      // 7: zero-valued npix/nch behave as 1
      run_cfg(0, 0, 0);
      beat(-5, 9, 0, 1);
      chk("t7_no_err", int'(err_ovr), 0);
      set_exp(0, -5, 9, 0, 1);
      collect(1, 1, -1, -2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
